// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register with wrap, redirect/fault handling, and the
// fetch FIFO feeding decode.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_inc, pc_seq;
    logic            redirect_take, target_legal;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    fetch_entry_t    wr_entry, head;

    assign pc_inc = pc_q + PC_STEP;
    assign pc_seq = (pc_inc == IMEM_LIMIT) ? '0 : pc_inc;

    // Once faulted, redirects are ignored until reset.
    assign redirect_take = redirect_valid && !fault_q;
    assign target_legal  = is_word_aligned(redirect_pc) && (redirect_pc < IMEM_LIMIT);

    assign pop  = !fifo_empty && out_ready;
    assign push = en && !fault_q && !redirect_valid && (!fifo_full || pop);

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_rdata;

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_take) begin
            if (target_legal) begin
                pc_d = redirect_pc;
            end else begin
                fault_d = 1'b1;
            end
        end else if (push) begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_take),
        .wdata_i (wr_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_addr   = pc_q;
    assign out_valid   = !fifo_empty;
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MEM_B    = 256;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst, en, out_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic        out_valid, fetch_fault;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: queue of {pc, instr}, current pc, sticky fault.
    logic [63:0] m_q [$];
    int unsigned m_pc;
    bit          m_fault;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (MEM_B),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        bit pop, push;
        rst            = r;
        en             = e;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;

        if (r) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_fault = 1'b0;
        end else if (rv && !m_fault) begin
            m_q.delete();
            if (rpc % 4 == 0 && rpc < MEM_B) m_pc = rpc;
            else m_fault = 1'b1;
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            push = e && !m_fault && !rv && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, mem[m_pc / 4]});
                m_pc = (m_pc + 4) % MEM_B;
            end
        end

        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
    endtask

    initial begin
        logic [31:0] tgt;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        mem[0] = 32'h0195_0533;
        @(negedge clk);

        // Reset state and first fetch
        cycle(1, 0, 0, 0, 0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        cycle(0, 1, 1, 0, 0);
        chk("first_instr", out_instr, 32'h0195_0533);
        chk("first_pc", out_pc, 32'd0);
        chk("first_addr", imem_addr, 32'd4);
        cycle(0, 1, 1, 0, 0);
        chk("step_addr8", imem_addr, 32'd8);
        cycle(0, 1, 1, 0, 0);
        chk("step_addr12", imem_addr, 32'd12);

        // Backpressure
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        chk("bp_addr_hold", imem_addr, 32'd8);
        chk("bp_head_pc", out_pc, 32'd0);
        cycle(0, 1, 1, 0, 0);
        chk("bp_rel_pc4", out_pc, 32'd4);
        cycle(0, 1, 1, 0, 0);
        chk("bp_rel_pc8", out_pc, 32'd8);
        chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);

        // Wrap at memory boundary
        cycle(0, 1, 1, 1, 32'd252);
        chk("wrap_redir_valid", {31'd0, out_valid}, 32'd0);
        cycle(0, 1, 1, 0, 0);
        chk("wrap_pc252", out_pc, 32'd252);
        chk("wrap_addr0", imem_addr, 32'd0);
        cycle(0, 1, 1, 0, 0);
        chk("wrap_pc0", out_pc, 32'd0);

        // Redirect while full
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 32'd16);
        chk("full_redir_valid", {31'd0, out_valid}, 32'd0);
        chk("full_redir_addr", imem_addr, 32'd16);
        cycle(0, 1, 1, 0, 0);
        chk("full_redir_pc", out_pc, 32'd16);

        // Illegal redirects
        cycle(0, 1, 1, 1, 32'd6);
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misalign_pc", imem_addr, 32'd20);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 32'd32);
        chk("fault_ignores_redir", imem_addr, 32'd20);
        chk("fault_no_push", {31'd0, out_valid}, 32'd0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_clears_fault", {31'd0, fetch_fault}, 32'd0);
        cycle(0, 1, 1, 1, 32'd256);
        chk("range_fault", {31'd0, fetch_fault}, 32'd1);
        chk("range_pc", imem_addr, RESET_PC);
        cycle(1, 0, 0, 0, 0);

        // Reset beats a same-cycle redirect while full
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 32'd40);
        chk("rst_redir_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redir_addr", imem_addr, RESET_PC);
        chk("rst_redir_fault", {31'd0, fetch_fault}, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0:       tgt = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       tgt = 32'd256 + ($urandom_range(0, 1000) * 4);
                default: tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 11) == 0,
                  tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
